// File: rtl/pt_history_pkg.sv
// rtl/pt_history_pkg.sv - shared types and helpers for the point-history ring
// Purpose: FSM state enum, stored point record and the brightness grading
//          function used when PT_HISTORY_FADING_EN is defined.
// Ports:   none (package).
package pt_history_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ERASE,
      ST_STORE,
      ST_RD,
      ST_DRAW,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] h;
   } point_t;

   // Brightness of point k of n (0 = oldest) in a ring of pc = 2**lg slots.
   // The newest point always lands on 255; older points step down linearly.
   function automatic logic [7:0] fade_v(input int k, input int n, input int pc, input int lg);
      int t;
      t = ((k + pc - n + 1) << (8 - lg)) - 1;
      if (t > 255) begin
         return 8'd255;
      end
      if (t < 0) begin
         return 8'd0;
      end
      return t[7:0];
   endfunction

endpackage

// File: rtl/pt_history_mem.sv
// rtl/pt_history_mem.sv - simple dual-port point RAM with registered read
// Purpose: DEPTH x 24-bit storage for the history ring; read data appears
//          one cycle after rd_en_i and holds until the next read.
// Ports:   clock; wr_en_i/wr_addr_i/wr_data_i write port;
//          rd_en_i/rd_addr_i read request; rd_data_o registered read data.
module pt_history_mem
   import pt_history_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  point_t        wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output point_t        rd_data_o
);

   point_t mem_q [DEPTH];
   point_t rd_data_q;

   // Read and write never address the same slot in one cycle, so no
   // write-through path is needed.
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pt_history_ring.sv
// rtl/pt_history_ring.sv - last-N point history with erase and full redraw
// Purpose: stores each accepted (x,y,hue) point in a ring of POINT_COUNT
//          slots; when full, erases the evicted point (v=0) first, then
//          redraws every stored point oldest-to-newest through fig_drawer.
//          Optional macro PT_HISTORY_FADING_EN grades brightness by age;
//          without it every drawn point uses V_MAX.
// Ports:   clock, reset (sync, active-high);
//          pt_x_i/pt_y_i/pt_h_i/pt_req_i in, pt_ack_o out (point handshake);
//          fig_x_o/fig_y_o/fig_h_o/fig_s_o/fig_v_o/fig_req_o out,
//          fig_ack_i in (drawer handshake); busy_o high outside IDLE.
module pt_history_ring
   import pt_history_pkg::*;
#(
   parameter int         POINT_COUNT = 128,
   parameter logic [7:0] SAT         = 8'd255,
   parameter logic [7:0] V_MAX       = 8'd255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] pt_x_i,
   input  logic [7:0] pt_y_i,
   input  logic [7:0] pt_h_i,
   input  logic       pt_req_i,
   output logic       pt_ack_o,
   output logic [7:0] fig_x_o,
   output logic [8:0] fig_y_o,
   output logic [7:0] fig_h_o,
   output logic [7:0] fig_s_o,
   output logic [7:0] fig_v_o,
   output logic       fig_req_o,
   input  logic       fig_ack_i,
   output logic       busy_o
);

   localparam int LG = $clog2(POINT_COUNT);
   localparam int CW = LG + 1;

   state_t        state_q, state_d;
   point_t        pt_q, pt_d;
   logic [LG-1:0] wr_ptr_q, wr_ptr_d;
   logic [LG-1:0] k_q, k_d;
   logic [CW-1:0] count_q, count_d;
   logic          erase_rd_q, erase_rd_d;
   logic          fig_req_q, fig_req_d;
   logic [7:0]    v_q, v_d;

   logic          rd_en;
   logic          wr_en;
   logic [LG-1:0] rd_addr;
   point_t        rd_data;

   pt_history_mem #(
      .DEPTH (POINT_COUNT),
      .AW    (LG)
   ) u_mem (
      .clock     (clock),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (pt_q),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   always_comb begin
      state_d    = state_q;
      pt_d       = pt_q;
      wr_ptr_d   = wr_ptr_q;
      k_d        = k_q;
      count_d    = count_q;
      erase_rd_d = erase_rd_q;
      fig_req_d  = fig_req_q;
      v_d        = v_q;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      // Oldest stored point sits count slots behind the write pointer.
      rd_addr    = wr_ptr_q - count_q[LG-1:0] + k_q;
      case (state_q)
         ST_IDLE: begin
            if (pt_req_i) begin
               pt_d       = '{x: pt_x_i, y: pt_y_i, h: pt_h_i};
               erase_rd_d = 1'b0;
               state_d    = (count_q == CW'(POINT_COUNT)) ? ST_ERASE : ST_STORE;
            end
         end
         ST_ERASE: begin
            // First cycle reads the slot about to be overwritten; the
            // request rises together with the read data.
            if (!erase_rd_q) begin
               rd_en      = 1'b1;
               rd_addr    = wr_ptr_q;
               erase_rd_d = 1'b1;
               fig_req_d  = 1'b1;
               v_d        = 8'd0;
            end else if (fig_ack_i) begin
               fig_req_d = 1'b0;
               state_d   = ST_STORE;
            end
         end
         ST_STORE: begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != CW'(POINT_COUNT)) begin
               count_d = count_q + 1'b1;
            end
            k_d     = '0;
            state_d = ST_RD;
         end
         ST_RD: begin
            rd_en     = 1'b1;
            fig_req_d = 1'b1;
`ifdef PT_HISTORY_FADING_EN
            v_d       = fade_v(int'(k_q), int'(count_q), POINT_COUNT, LG);
`else
            v_d       = V_MAX;
`endif
            state_d   = ST_DRAW;
         end
         ST_DRAW: begin
            if (fig_ack_i) begin
               fig_req_d = 1'b0;
               if ({1'b0, k_q} == count_q - CW'(1)) begin
                  state_d = ST_DONE;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = ST_RD;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            fig_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pt_q       <= '0;
         wr_ptr_q   <= '0;
         k_q        <= '0;
         count_q    <= '0;
         erase_rd_q <= 1'b0;
         fig_req_q  <= 1'b0;
         v_q        <= '0;
      end else begin
         state_q    <= state_d;
         pt_q       <= pt_d;
         wr_ptr_q   <= wr_ptr_d;
         k_q        <= k_d;
         count_q    <= count_d;
         erase_rd_q <= erase_rd_d;
         fig_req_q  <= fig_req_d;
         v_q        <= v_d;
      end
   end

   // RAM read data is held between reads, so gating with the request keeps
   // fig_* stable during a request and zero otherwise.
   assign fig_req_o = fig_req_q;
   assign fig_x_o   = fig_req_q ? rd_data.x : '0;
   assign fig_y_o   = fig_req_q ? {1'b0, rd_data.y} : '0;
   assign fig_h_o   = fig_req_q ? rd_data.h : '0;
   assign fig_s_o   = fig_req_q ? SAT : '0;
   assign fig_v_o   = fig_req_q ? v_q : '0;
   assign pt_ack_o  = (state_q == ST_DONE);
   assign busy_o    = (state_q != ST_IDLE);

endmodule
